// File: rtl/rom_lookup_stage.sv
// rom_lookup_stage: issue/return stage around a registered 2-port ROM.
// Ports: lookup in (valid/ready, addr a/b, tag), ROM addr out / data in,
//        result out (valid/ready, qa, qb, hit, tag), lookup/hit statistics.
module rom_lookup_stage #(
    parameter int AWIDTH     = 8,
    parameter int DWIDTH     = 8,
    parameter int TWIDTH     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CWIDTH     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] in_addr_a,
    input  logic [AWIDTH-1:0] in_addr_b,
    input  logic [TWIDTH-1:0] in_tag,
    output logic [AWIDTH-1:0] rom_addr_a,
    output logic [AWIDTH-1:0] rom_addr_b,
    input  logic [DWIDTH-1:0] rom_qa,
    input  logic [DWIDTH-1:0] rom_qb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_qa,
    output logic [DWIDTH-1:0] out_qb,
    output logic [1:0]        out_hit,
    output logic [TWIDTH-1:0] out_tag,
    output logic [CWIDTH-1:0] stat_lookups,
    output logic [CWIDTH-1:0] stat_hits
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    // issue side
    logic              r_in_ready;
    logic              r_inflight;
    logic [TWIDTH-1:0] r_tag_s1;

    // FIFO storage; rd pointer always names the slot mirrored in r_out_*
    logic [DWIDTH-1:0] r_mem_qa  [FIFO_DEPTH];
    logic [DWIDTH-1:0] r_mem_qb  [FIFO_DEPTH];
    logic [1:0]        r_mem_hit [FIFO_DEPTH];
    logic [TWIDTH-1:0] r_mem_tag [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [NW-1:0]     r_count;

    // registered head
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_qa;
    logic [DWIDTH-1:0] r_out_qb;
    logic [1:0]        r_out_hit;
    logic [TWIDTH-1:0] r_out_tag;

    logic [CWIDTH-1:0] r_stat_lookups;
    logic [CWIDTH-1:0] r_stat_hits;

    logic              w_fire;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_push_hit;
    logic [NW-1:0]     w_cnt_pop;
    logic [NW-1:0]     w_cnt_next;
    logic [NW:0]       w_credit;
    logic              w_ready_next;
    logic [PW-1:0]     w_rd_inc;
    logic [PW-1:0]     w_wr_inc;

    assign rom_addr_a = in_addr_a;
    assign rom_addr_b = in_addr_b;

    assign w_fire     = in_valid & r_in_ready;
    // ROM data is valid the cycle after a fire, so the push is the
    // delayed fire itself
    assign w_push     = r_inflight;
    assign w_pop      = r_out_valid & out_ready;
    assign w_push_hit = {|rom_qb, |rom_qa};

    assign w_cnt_pop  = r_count - NW'(w_pop);
    assign w_cnt_next = w_cnt_pop + NW'(w_push);

    // Credits count the lookup issued this cycle, so a slot is always
    // reserved before its ROM data returns.
    assign w_credit     = {1'b0, w_cnt_next} + (NW+1)'(w_fire);
    assign w_ready_next = w_credit < (NW+1)'(FIFO_DEPTH);

    assign w_rd_inc = r_rd_ptr + PW'(1);
    assign w_wr_inc = r_wr_ptr + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_inflight <= 1'b0;
            r_tag_s1   <= '0;
        end else begin
            r_in_ready <= w_ready_next;
            r_inflight <= w_fire;
            if (w_fire) begin
                r_tag_s1 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_qa[r_wr_ptr]  <= rom_qa;
            r_mem_qb[r_wr_ptr]  <= rom_qb;
            r_mem_hit[r_wr_ptr] <= w_push_hit;
            r_mem_tag[r_wr_ptr] <= r_tag_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_cnt_next;
            if (w_push) begin
                r_wr_ptr <= w_wr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_inc;
            end
        end
    end

    // Head refresh: after a pop the next entry comes from storage; an
    // entry pushed into an empty (or just-emptied) FIFO is taken straight
    // from the ROM. Otherwise the head holds still.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_qa    <= '0;
            r_out_qb    <= '0;
            r_out_hit   <= '0;
            r_out_tag   <= '0;
        end else begin
            r_out_valid <= (w_cnt_next != '0);
            if (w_pop && (w_cnt_pop != '0)) begin
                r_out_qa  <= r_mem_qa[w_rd_inc];
                r_out_qb  <= r_mem_qb[w_rd_inc];
                r_out_hit <= r_mem_hit[w_rd_inc];
                r_out_tag <= r_mem_tag[w_rd_inc];
            end else if (w_push && (w_cnt_pop == '0)) begin
                r_out_qa  <= rom_qa;
                r_out_qb  <= rom_qb;
                r_out_hit <= w_push_hit;
                r_out_tag <= r_tag_s1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
        end else begin
            if (w_fire) begin
                r_stat_lookups <= r_stat_lookups + CWIDTH'(1);
            end
            if (w_pop && (r_out_hit != 2'b00)) begin
                r_stat_hits <= r_stat_hits + CWIDTH'(1);
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_qa       = r_out_qa;
    assign out_qb       = r_out_qb;
    assign out_hit      = r_out_hit;
    assign out_tag      = r_out_tag;
    assign stat_lookups = r_stat_lookups;
    assign stat_hits    = r_stat_hits;

endmodule

// File: tb/tb_rom_lookup_stage.sv
// tb_rom_lookup_stage: directed bench for rom_lookup_stage with a
// registered ROM model and an expected-result queue.
module tb_rom_lookup_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_addr_a;
    logic [7:0]  in_addr_b;
    logic [15:0] in_tag;
    logic [7:0]  rom_addr_a;
    logic [7:0]  rom_addr_b;
    logic [7:0]  rom_qa;
    logic [7:0]  rom_qb;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_qa;
    logic [7:0]  out_qb;
    logic [1:0]  out_hit;
    logic [15:0] out_tag;
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  qa;
        logic [7:0]  qb;
        logic [15:0] tag;
    } exp_t;

    exp_t q[$];

    // values observed at the most recent drive() call
    logic        s_rdy, s_ov, s_fire, s_pop;
    logic [7:0]  s_qa, s_qb;
    logic [1:0]  s_hit;
    logic [15:0] s_tag;

    always #5 clk = ~clk;

    rom_lookup_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr_a    (in_addr_a),
        .in_addr_b    (in_addr_b),
        .in_tag       (in_tag),
        .rom_addr_a   (rom_addr_a),
        .rom_addr_b   (rom_addr_b),
        .rom_qa       (rom_qa),
        .rom_qb       (rom_qb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_qa       (out_qa),
        .out_qb       (out_qb),
        .out_hit      (out_hit),
        .out_tag      (out_tag),
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits)
    );

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        if (a == 8'h10) return 8'h00;
        if (a == 8'h03) return 8'h5A;
        if (a[2:0] == 3'd0) return 8'h00;
        return a ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        rom_qa <= rom_f(rom_addr_a);
        rom_qb <= rom_f(rom_addr_b);
    end

    // Sets inputs at a negedge; records what the next posedge will do.
    task automatic drive(input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] t,
                         input logic ordy);
        exp_t e;
        @(negedge clk);
        s_rdy = in_ready;
        s_ov  = out_valid;
        s_qa  = out_qa;
        s_qb  = out_qb;
        s_hit = out_hit;
        s_tag = out_tag;
        in_valid  = v;
        in_addr_a = a;
        in_addr_b = b;
        in_tag    = t;
        out_ready = ordy;
        s_fire = v & in_ready;
        s_pop  = out_valid & ordy;
        if (s_fire) begin
            e.qa  = rom_f(a);
            e.qb  = rom_f(b);
            e.tag = t;
            q.push_back(e);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1; in_addr_a = 0; in_addr_b = 0;
        in_tag = 0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 ||
                stat_lookups !== 0 || stat_hits !== 0) begin
                fails++;
                $display("FAIL reset_state: rdy=%b ov=%b lk=%0d hit=%0d want 0",
                         in_ready, out_valid, stat_lookups, stat_hits);
            end
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: rdy=%b ov=%b want rdy=1 ov=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_single;
        drive(1, 8'h03, 8'h10, 16'h0042, 1);
        tests++;
        if (s_fire !== 1'b1) begin
            fails++;
            $display("FAIL single_fire: got %b want 1", s_fire);
        end
        drive(0, 0, 0, 0, 1);
        tests++;
        if (s_ov !== 1'b0) begin
            fails++;
            $display("FAIL single_latency1: ov=%b want 0", s_ov);
        end
        drive(0, 0, 0, 0, 1);
        tests++;
        if ({s_ov, s_qa, s_qb, s_hit, s_tag} !==
            {1'b1, 8'h5A, 8'h00, 2'b01, 16'h0042}) begin
            fails++;
            $display("FAIL single_result: ov=%b qa=%h qb=%h hit=%b tag=%h want 1 5a 00 01 0042",
                     s_ov, s_qa, s_qb, s_hit, s_tag);
        end
        if (s_pop) void'(q.pop_front());
        drive(0, 0, 0, 0, 1);
        tests++;
        if (s_ov !== 1'b0 || stat_hits !== 1 || stat_lookups !== 1) begin
            fails++;
            $display("FAIL single_stats: ov=%b hits=%0d lk=%0d want 0 1 1",
                     s_ov, stat_hits, stat_lookups);
        end
    endtask

    task automatic test_streaming;
        exp_t e;
        int n = 0;
        int pops = 0;
        int lk0 = stat_lookups;
        int hit0 = stat_hits;
        int exp_hits = 0;
        logic [7:0] a, b;
        for (int c = 0; c < 120; c++) begin
            a = 8'(n);
            b = 8'(n * 7 + 1);
            drive(n < 100, a, b, 16'h1000 + 16'(n), 1);
            if (n < 100) begin
                tests++;
                if (s_rdy !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_ready: cycle %0d rdy=%b want 1", c, s_rdy);
                end
            end
            if (s_pop) begin
                tests++;
                pops++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: tag=%h want none", s_tag);
                end else begin
                    e = q.pop_front();
                    if (e.qa != 0 || e.qb != 0) exp_hits++;
                    if ({s_qa, s_qb, s_hit, s_tag} !==
                        {e.qa, e.qb, |e.qb, |e.qa, e.tag}) begin
                        fails++;
                        $display("FAIL stream_data: got %h %h %b %h want %h %h %b%b %h",
                                 s_qa, s_qb, s_hit, s_tag, e.qa, e.qb,
                                 |e.qb, |e.qa, e.tag);
                    end
                end
            end
            if (s_fire) n++;
        end
        tests++;
        if (pops != 100 || q.size() != 0 || stat_lookups - lk0 != 100 ||
            stat_hits - hit0 != exp_hits) begin
            fails++;
            $display("FAIL stream_totals: pops=%0d left=%0d lk=%0d hits=%0d want 100 0 100 %0d",
                     pops, q.size(), stat_lookups - lk0, stat_hits - hit0, exp_hits);
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int n = 0;
        int pops = 0;
        logic        held = 1'b0;
        logic [7:0]  hqa, hqb;
        logic [1:0]  hhit;
        logic [15:0] htag;
        for (int c = 0; c < 16; c++) begin
            drive(1, 8'(8'h20 + n), 8'(8'h40 + n), 16'h2000 + 16'(n), 0);
            if (s_ov) begin
                if (!held) begin
                    held = 1'b1;
                    {hqa, hqb, hhit, htag} = {s_qa, s_qb, s_hit, s_tag};
                end else begin
                    tests++;
                    if ({s_qa, s_qb, s_hit, s_tag} !== {hqa, hqb, hhit, htag}) begin
                        fails++;
                        $display("FAIL bp_stable: got %h %h %b %h want %h %h %b %h",
                                 s_qa, s_qb, s_hit, s_tag, hqa, hqb, hhit, htag);
                    end
                end
            end
            if (s_fire) n++;
        end
        tests++;
        if (n != 8 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept: accepted=%0d rdy=%b want 8 0", n, in_ready);
        end
        for (int c = 0; c < 14; c++) begin
            drive(0, 0, 0, 0, 1);
            if (s_pop) begin
                tests++;
                pops++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: tag=%h want none", s_tag);
                end else begin
                    e = q.pop_front();
                    if ({s_qa, s_qb, s_hit, s_tag} !==
                        {e.qa, e.qb, |e.qb, |e.qa, e.tag}) begin
                        fails++;
                        $display("FAIL bp_data: got %h %h %b %h want %h %h %b%b %h",
                                 s_qa, s_qb, s_hit, s_tag, e.qa, e.qb,
                                 |e.qb, |e.qa, e.tag);
                    end
                end
            end
        end
        tests++;
        if (pops != 8 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: pops=%0d rdy=%b ov=%b want 8 1 0",
                     pops, in_ready, out_valid);
        end
    endtask

    task automatic test_full_push_pop;
        exp_t e;
        int n = 0;
        int pops = 0;
        logic ordy;
        for (int c = 0; c < 70; c++) begin
            // stall until 8 accepted, then a gappy consumer, then drain
            ordy = (n >= 8) && (c % 3 != 0 || c > 45);
            drive((n < 40) && (c < 45), 8'(n + 3), 8'(n * 3), 16'h3000 + 16'(n), ordy);
            if (s_pop) begin
                tests++;
                pops++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL full_extra: tag=%h want none", s_tag);
                end else begin
                    e = q.pop_front();
                    if ({s_qa, s_qb, s_hit, s_tag} !==
                        {e.qa, e.qb, |e.qb, |e.qa, e.tag}) begin
                        fails++;
                        $display("FAIL full_data: got %h %h %b %h want %h %h %b%b %h",
                                 s_qa, s_qb, s_hit, s_tag, e.qa, e.qb,
                                 |e.qb, |e.qa, e.tag);
                    end
                end
            end
            if (s_fire) n++;
        end
        tests++;
        if (pops != n || q.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_totals: pops=%0d pushes=%0d left=%0d ov=%b want equal 0 0",
                     pops, n, q.size(), out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        int n = 0;
        logic got = 1'b0;
        for (int c = 0; c < 10 && n < 6; c++) begin
            drive(1, 8'(8'h50 + n), 8'h03, 16'h4000 + 16'(n), 0);
            if (s_fire) n++;
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_prefill: ov=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || stat_lookups !== 0) begin
            fails++;
            $display("FAIL mid_async: ov=%b rdy=%b lk=%0d want 0 0 0",
                     out_valid, in_ready, stat_lookups);
        end
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1);
        drive(1, 8'h03, 8'h0B, 16'hBEEF, 1);
        for (int c = 0; c < 8 && !got; c++) begin
            drive(0, 0, 0, 0, 1);
            if (s_pop) begin
                got = 1'b1;
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL mid_extra: tag=%h want none", s_tag);
                end else begin
                    e = q.pop_front();
                    if ({s_qa, s_qb, s_hit, s_tag} !==
                        {e.qa, e.qb, |e.qb, |e.qa, e.tag}) begin
                        fails++;
                        $display("FAIL mid_first: got %h %h %b %h want %h %h %b%b %h",
                                 s_qa, s_qb, s_hit, s_tag, e.qa, e.qb,
                                 |e.qb, |e.qa, e.tag);
                    end
                end
            end
        end
        drive(0, 0, 0, 0, 1);
        tests++;
        if (!got || s_ov !== 1'b0 || stat_lookups !== 1 || stat_hits !== 1) begin
            fails++;
            $display("FAIL mid_after: got=%b ov=%b lk=%0d hits=%0d want 1 0 1 1",
                     got, s_ov, stat_lookups, stat_hits);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_streaming;
        test_backpressure;
        test_full_push_pop;
        test_reset_midstream;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
